// File: rtl/link_pkg.sv
// Shared link definitions: FSM state encoding, byte width and parameter limits.
// Used by both the link slave receiver and the link master.
package link_pkg;
   localparam int BYTE_W        = 8;
   localparam int MAX_BURST_LEN = 16;
   localparam int MAX_ACK_DELAY = 15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_ACK   = 2'd2
   } link_state_e;
endpackage

// File: rtl/link_rx_csum.sv
// 8-bit modulo-256 accumulator with synchronous clear and add enables.
// Clear wins over add; the sum register is reset asynchronously.
module link_rx_csum
   import link_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              add_i,
   input  logic [BYTE_W-1:0] din_i,
   output logic [BYTE_W-1:0] sum_o
);
   logic [BYTE_W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr_i)
         sum_d = '0;
      else if (add_i)
         sum_d = sum_q + din_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sum_q <= '0;
      else
         sum_q <= sum_d;
   end

   assign sum_o = sum_q;
endmodule

// File: rtl/link_slave_rx.sv
// 4-phase handshake slave: captures bytes into a staging burst, publishes full bursts.
// Optional running checksum enabled by macro LINK_RX_CSUM_EN (otherwise csum reads 0).
module link_slave_rx
   import link_pkg::*;
#(
   parameter int BURST_LEN = 4,
   parameter int ACK_DELAY = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req,
   input  logic [BYTE_W-1:0]           data,
   output logic                        ack,
   output logic                        byte_valid,
   output logic [BYTE_W-1:0]           last_byte,
   output logic [BYTE_W*BURST_LEN-1:0] burst_data,
   output logic                        burst_done,
   output logic [3:0]                  byte_idx,
   output logic                        proto_err,
   output logic [BYTE_W-1:0]           csum
);
   localparam logic [3:0] LAST_IDX = 4'(BURST_LEN - 1);
   localparam logic [3:0] DLY_LOAD = 4'(ACK_DELAY);

   link_state_e                 state_q, state_d;
   logic [3:0]                  cnt_q, cnt_d;
   logic                        ack_q, ack_d, bv_q, bv_d, done_q, done_d, err_q, err_d;
   logic [3:0]                  idx_q, idx_d;
   logic [BYTE_W-1:0]           last_q, last_d;
   logic [BYTE_W*BURST_LEN-1:0] stage_q, stage_d, burst_q, burst_d;
   logic                        cap, fin, abort;

   assign cap   = (state_q == S_IDLE)  && req;
   assign fin   = (state_q == S_ACK)   && !req;
   assign abort = (state_q == S_DELAY) && !req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req) state_d = (ACK_DELAY == 0) ? S_ACK : S_DELAY;
         S_DELAY: if (!req) state_d = S_IDLE;
                  else if (cnt_q == 4'd1) state_d = S_ACK;
         S_ACK:   if (!req) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Staging slot is written at capture; an aborted byte is simply overwritten later.
   always_comb begin
      ack_d   = (state_d == S_ACK);
      bv_d    = fin;
      err_d   = abort;
      done_d  = fin && (idx_q == LAST_IDX);
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      last_d  = last_q;
      stage_d = stage_q;
      burst_d = burst_q;
      if (cap) begin
         cnt_d  = DLY_LOAD;
         last_d = data;
         stage_d[int'(idx_q)*BYTE_W +: BYTE_W] = data;
      end else if (state_q == S_DELAY) begin
         cnt_d = cnt_q - 4'd1;
      end
      if (fin)
         idx_d = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
      if (done_d)
         burst_d = stage_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         bv_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         last_q  <= '0;
         stage_q <= '0;
         burst_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         bv_q    <= bv_d;
         done_q  <= done_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         stage_q <= stage_d;
         burst_q <= burst_d;
      end
   end

   assign ack        = ack_q;
   assign byte_valid = bv_q;
   assign burst_done = done_q;
   assign proto_err  = err_q;
   assign byte_idx   = idx_q;
   assign last_byte  = last_q;
   assign burst_data = burst_q;

`ifdef LINK_RX_CSUM_EN
   link_rx_csum u_csum (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cap && (idx_q == 4'd0)),
      .add_i (fin),
      .din_i (last_q),
      .sum_o (csum)
   );
`else
   assign csum = 8'h00;
`endif
endmodule
